ysyx_cdb_arb: RTL and testbench
===============================

Name: ysyx_cdb_arb

Overview:
Writeback arbiter that shares the single EXU result bus (common data bus) among N functional-unit requesters (ALU, LSU, MUL/DIV, ...). Each cycle it grants one requester, registers the winning result in one output stage, and holds it until the ROB accepts it. The output feeds ROB writeback and reservation-station wakeup (dest/result broadcast). Selection is oldest-first by ROB tag relative to the ROB head, or round-robin.

Parameters:
N_REQ, 3, number of requesting functional units (2..8)
XLEN, 32, result/npc/pc width
ROB_SIZE, 8, ROB entries; tag width TW = $clog2(ROB_SIZE)+1 (includes wrap bit)
OLDEST_FIRST, 1, 1 = age priority by ROB tag, 0 = pure round-robin

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  pipeline flush (mispredict/trap); kills the held output and blocks grants this cycle
rob_head  in  TW  ROB head tag, oldest in-flight entry
req_valid  in  N_REQ  per-unit result valid
req_ready  out  N_REQ  per-unit accept; handshake when valid&ready
req_dest  in  N_REQ*TW  per-unit ROB tag, unit i at [i*TW +: TW]
req_result  in  N_REQ*XLEN  per-unit result
req_npc  in  N_REQ*XLEN  per-unit resolved next PC
req_pc  in  N_REQ*XLEN  per-unit instruction PC
req_br_retire  in  N_REQ  branch/jump resolved flag
req_sys_retire  in  N_REQ  system instruction flag
cdb_valid  out  1  output entry valid
cdb_ready  in  1  ROB accepts output this cycle
cdb_dest, cdb_result, cdb_npc, cdb_pc  out  TW, XLEN, XLEN, XLEN  registered winning payload
cdb_br_retire, cdb_sys_retire  out  1, 1  registered flags
cdb_src  out  $clog2(N_REQ)  index of the unit that produced the output entry

Behaviour:
- Reset: cdb_valid=0, all cdb_* payload=0, cdb_src=0, rr_ptr=0; req_ready=0 during reset.
- can_load = !cdb_valid | cdb_ready. Grant is combinational: at most one req_ready bit set, and only when can_load & !flush & !reset.
- Grant selection, OLDEST_FIRST=1: age_i = (req_dest_i - rob_head) mod 2^TW, unsigned TW-bit. The valid requester with the smallest age wins. Equal ages are illegal upstream; on equal ages the round-robin order breaks the tie.
- Grant selection, OLDEST_FIRST=0: first valid index at or after rr_ptr, scanning with wrap mod N_REQ.
- rr_ptr update: on a handshake with unit g, rr_ptr <= (g+1) mod N_REQ, with N_REQ not a power of two handled explicitly. Otherwise rr_ptr holds.
- Output register: on a handshake the payload and cdb_src load next edge and cdb_valid<=1. Else if cdb_ready, cdb_valid<=0. Else hold; payload stays stable while cdb_valid & !cdb_ready.
- Latency: a result accepted in cycle t is on cdb_* in cycle t+1. Back-to-back throughput is 1 result/cycle while cdb_ready=1.
- Simultaneous cdb_ready and new grant: the new entry replaces the old one (no bubble).
- flush: cdb_valid<=0 next edge and req_ready=0 that cycle, so requesters hold or drop per their own flush. rr_ptr holds. flush has priority over cdb_ready/grant.
- reset mid-operation: same as the reset values; any held output is discarded.
- No requester is starved in RR mode: the wait is bounded by N_REQ-1 grants. In age mode the oldest entry always progresses.
- Unit i holding req_valid with changing payload before its handshake is illegal; the bench asserts payload stability.
- Assertions: $onehot0(req_ready); cdb payload stable while cdb_valid&!cdb_ready; no req_ready while flush.

Test Plan:
1. After reset, only unit 1 valid with dest=3, result=0xDEADBEEF, cdb_ready=1 -> req_ready=3'b010 at cycle t; at t+1 cdb_valid=1, cdb_dest=3, cdb_result=0xDEADBEEF, cdb_src=1.
2. OLDEST_FIRST=1, rob_head=6 (TW=4), units 0/1/2 dest=2/7/14 all valid -> grant order unit1 (age1), unit2 (age8), unit0 (age12) on consecutive cycles, output cycles t+1..t+3.
3. OLDEST_FIRST=0, all 3 units continuously valid, cdb_ready=1 -> grants 0,1,2,0,1,2; cdb_src sequence lags by one cycle.
4. cdb_valid=1 holding dest=5, cdb_ready=0 for 3 cycles with unit0 valid -> req_ready=0 and cdb_dest=5 stable. Then cdb_ready=1 -> unit0 granted the same cycle, new entry visible the next cycle with no bubble.
5. Output valid, unit2 valid, flush=1 for one cycle -> req_ready=0, cdb_valid=0 next cycle, rr_ptr unchanged. Unit2 granted the cycle after flush drops.
6. reset asserted while cdb_valid=1 and requests pending -> next cycle cdb_valid=0, payload=0, rr_ptr=0. With OLDEST_FIRST=0 the first grant after reset goes to the lowest valid index.

Source files
------------

// File: rtl/ysyx_cdb_arb_if.sv
// Common-data-bus writeback bundle: per-unit result requests in, one registered
// result broadcast out. The arbiter drives the master side.
interface ysyx_cdb_arb_if #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32,
  parameter int TW    = 4,
  parameter int SW    = $clog2(N_REQ)
);
  logic                  flush;
  logic [TW-1:0]         rob_head;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*TW-1:0]   req_dest;
  logic [N_REQ*XLEN-1:0] req_result;
  logic [N_REQ*XLEN-1:0] req_npc;
  logic [N_REQ*XLEN-1:0] req_pc;
  logic [N_REQ-1:0]      req_br_retire;
  logic [N_REQ-1:0]      req_sys_retire;
  logic                  cdb_valid;
  logic                  cdb_ready;
  logic [TW-1:0]         cdb_dest;
  logic [XLEN-1:0]       cdb_result;
  logic [XLEN-1:0]       cdb_npc;
  logic [XLEN-1:0]       cdb_pc;
  logic                  cdb_br_retire;
  logic                  cdb_sys_retire;
  logic [SW-1:0]         cdb_src;

  modport master (
    input  flush, rob_head, req_valid, req_dest, req_result, req_npc, req_pc,
           req_br_retire, req_sys_retire, cdb_ready,
    output req_ready, cdb_valid, cdb_dest, cdb_result, cdb_npc, cdb_pc,
           cdb_br_retire, cdb_sys_retire, cdb_src
  );

  modport slave (
    output flush, rob_head, req_valid, req_dest, req_result, req_npc, req_pc,
           req_br_retire, req_sys_retire, cdb_ready,
    input  req_ready, cdb_valid, cdb_dest, cdb_result, cdb_npc, cdb_pc,
           cdb_br_retire, cdb_sys_retire, cdb_src
  );
endinterface

// File: rtl/ysyx_cdb_arb.sv
// Writeback arbiter: grants one functional unit per cycle onto the shared result
// bus (oldest ROB tag first, or round-robin) through a single output register.
module ysyx_cdb_arb #(
  parameter int N_REQ        = 3,
  parameter int XLEN         = 32,
  parameter int ROB_SIZE     = 8,
  parameter int OLDEST_FIRST = 1,
  localparam int TW          = $clog2(ROB_SIZE) + 1,
  localparam int SW          = $clog2(N_REQ)
) (
  input logic          clock,
  input logic          reset,
  ysyx_cdb_arb_if.master bus
);

  typedef struct packed {
    logic [TW-1:0]   dest;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc;
    logic            br_retire;
    logic            sys_retire;
  } entry_t;

  logic [TW-1:0]   dest_arr   [N_REQ];
  logic [XLEN-1:0] result_arr [N_REQ];
  logic [XLEN-1:0] npc_arr    [N_REQ];
  logic [XLEN-1:0] pc_arr     [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign dest_arr[i]   = bus.req_dest[i*TW +: TW];
    assign result_arr[i] = bus.req_result[i*XLEN +: XLEN];
    assign npc_arr[i]    = bus.req_npc[i*XLEN +: XLEN];
    assign pc_arr[i]     = bus.req_pc[i*XLEN +: XLEN];
  end

  entry_t           cdb_q;
  logic             cdb_valid_q;
  logic [SW-1:0]    cdb_src_q;
  logic [SW-1:0]    rr_ptr;

  logic             can_load;
  logic             grant_ok;
  logic             gnt_any;
  logic [SW-1:0]    gnt_idx;
  logic [TW-1:0]    best_age;
  logic [TW-1:0]    age;
  logic [SW:0]      scan;
  logic [SW-1:0]    scan_idx;
  logic [N_REQ-1:0] gnt_vec;
  logic             handshake;
  logic [SW-1:0]    rr_next;

  assign can_load  = !cdb_valid_q || bus.cdb_ready;
  assign grant_ok  = can_load && !bus.flush && !reset;
  assign handshake = grant_ok && gnt_any;

  // Scan in round-robin order from rr_ptr; in age mode a later candidate only
  // wins with a strictly smaller age, so ties fall back to round-robin order.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    best_age = '0;
    age      = '0;
    scan     = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (SW+1)'(k);
      if (scan >= (SW+1)'(N_REQ)) scan = scan - (SW+1)'(N_REQ);
      scan_idx = scan[SW-1:0];
      age      = dest_arr[scan_idx] - bus.rob_head;
      if (bus.req_valid[scan_idx] &&
          (!gnt_any || (OLDEST_FIRST != 0 && age < best_age))) begin
        gnt_any  = 1'b1;
        gnt_idx  = scan_idx;
        best_age = age;
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_vec[i] = handshake && (gnt_idx == SW'(i));
    end
  end

  // Explicit wrap so a non-power-of-two N_REQ never points past the last unit.
  assign rr_next = (gnt_idx == SW'(N_REQ - 1)) ? '0 : gnt_idx + SW'(1);

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the payload register is reset too, so a discarded entry never leaks stale data.
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= '0;
      rr_ptr      <= '0;
    end else if (handshake) begin
      cdb_q       <= '{dest:       dest_arr[gnt_idx],
                       result:     result_arr[gnt_idx],
                       npc:        npc_arr[gnt_idx],
                       pc:         pc_arr[gnt_idx],
                       br_retire:  bus.req_br_retire[gnt_idx],
                       sys_retire: bus.req_sys_retire[gnt_idx]};
      cdb_valid_q <= 1'b1;
      cdb_src_q   <= gnt_idx;
      rr_ptr      <= rr_next;
    end else if (bus.flush || bus.cdb_ready) begin
      cdb_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready      = gnt_vec;
  assign bus.cdb_valid      = cdb_valid_q;
  assign bus.cdb_dest       = cdb_q.dest;
  assign bus.cdb_result     = cdb_q.result;
  assign bus.cdb_npc        = cdb_q.npc;
  assign bus.cdb_pc         = cdb_q.pc;
  assign bus.cdb_br_retire  = cdb_q.br_retire;
  assign bus.cdb_sys_retire = cdb_q.sys_retire;
  assign bus.cdb_src        = cdb_src_q;

  a_ready_onehot: assert property (@(posedge clock) $onehot0(bus.req_ready));
  a_no_grant_on_flush: assert property (@(posedge clock) bus.flush |-> (bus.req_ready == '0));
  a_payload_stable: assert property (@(posedge clock) disable iff (reset)
    (cdb_valid_q && !bus.cdb_ready) |=> ($stable(cdb_q) && $stable(cdb_src_q)));

endmodule

// File: tb/tb_ysyx_cdb_arb.sv
// Bench for ysyx_cdb_arb: an age-priority and a round-robin instance driven by
// directed steps then random traffic, checked against an arithmetic model.
module tb_ysyx_cdb_arb;
  localparam int N    = 3;
  localparam int XLEN = 32;
  localparam int TW   = 4;
  localparam int SW   = 2;

  logic clock;
  logic reset;
  logic flush;
  logic cdb_ready;
  logic [TW-1:0] rob_head;

  logic [N-1:0]    rq_valid  [2];
  logic [TW-1:0]   rq_dest   [2][N];
  logic [XLEN-1:0] rq_result [2][N];
  logic [XLEN-1:0] rq_npc    [2][N];
  logic [XLEN-1:0] rq_pc     [2][N];
  logic            rq_br     [2][N];
  logic            rq_sys    [2][N];

  logic            o_valid  [2];
  logic [N-1:0]    o_ready  [2];
  logic [TW-1:0]   o_dest   [2];
  logic [XLEN-1:0] o_result [2];
  logic [XLEN-1:0] o_npc    [2];
  logic [XLEN-1:0] o_pc     [2];
  logic            o_br     [2];
  logic            o_sys    [2];
  logic [SW-1:0]   o_src    [2];

  // Instance 0 is age-priority, instance 1 is round-robin.
  for (genvar m = 0; m < 2; m++) begin : g_dut
    ysyx_cdb_arb_if #(.N_REQ(N), .XLEN(XLEN), .TW(TW)) bus ();
    ysyx_cdb_arb #(.N_REQ(N), .XLEN(XLEN), .ROB_SIZE(8), .OLDEST_FIRST(m == 0 ? 1 : 0))
      dut (.clock(clock), .reset(reset), .bus(bus));
    assign bus.flush     = flush;
    assign bus.rob_head  = rob_head;
    assign bus.cdb_ready = cdb_ready;
    assign bus.req_valid = rq_valid[m];
    for (genvar i = 0; i < N; i++) begin : g_req
      assign bus.req_dest[i*TW +: TW]         = rq_dest[m][i];
      assign bus.req_result[i*XLEN +: XLEN]   = rq_result[m][i];
      assign bus.req_npc[i*XLEN +: XLEN]      = rq_npc[m][i];
      assign bus.req_pc[i*XLEN +: XLEN]       = rq_pc[m][i];
      assign bus.req_br_retire[i]             = rq_br[m][i];
      assign bus.req_sys_retire[i]            = rq_sys[m][i];
    end
    assign o_valid[m]  = bus.cdb_valid;
    assign o_ready[m]  = bus.req_ready;
    assign o_dest[m]   = bus.cdb_dest;
    assign o_result[m] = bus.cdb_result;
    assign o_npc[m]    = bus.cdb_npc;
    assign o_pc[m]     = bus.cdb_pc;
    assign o_br[m]     = bus.cdb_br_retire;
    assign o_sys[m]    = bus.cdb_sys_retire;
    assign o_src[m]    = bus.cdb_src;
  end

  typedef struct {
    logic            valid;
    logic [TW-1:0]   dest;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc;
    logic            br;
    logic            sys;
    int              src;
  } mdl_t;

  mdl_t         mdl     [2];
  int           mdl_rr  [2];
  int           mdl_gnt [2];
  logic [N-1:0] act_rdy [2];
  string        pfx     [2] = '{"age", "rr"};
  int           refill;
  int           n_checks;
  int           n_fail;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Expected winner from the rules: candidates listed in round-robin order from
  // the pointer; age mode takes the smallest wrap-around distance from the head.
  function automatic int model_grant(input int m);
    int order[$];
    int min_age;
    if (reset || flush || (mdl[m].valid && !cdb_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      if (rq_valid[m][(mdl_rr[m] + k) % N]) order.push_back((mdl_rr[m] + k) % N);
    end
    if (order.size() == 0) return -1;
    if (m == 1) return order[0];
    min_age = 1 << TW;
    foreach (order[j]) begin
      int a = (int'(rq_dest[m][order[j]]) - int'(rob_head) + (1 << TW)) % (1 << TW);
      if (a < min_age) min_age = a;
    end
    foreach (order[j]) begin
      int a = (int'(rq_dest[m][order[j]]) - int'(rob_head) + (1 << TW)) % (1 << TW);
      if (a == min_age) return order[j];
    end
    return -1;
  endfunction

  task automatic new_req(input int m, input int i);
    rq_valid[m][i]  = 1'b1;
    rq_dest[m][i]   = TW'($urandom);
    rq_result[m][i] = $urandom;
    rq_npc[m][i]    = $urandom;
    rq_pc[m][i]     = $urandom;
    rq_br[m][i]     = 1'($urandom);
    rq_sys[m][i]    = 1'($urandom);
  endtask

  task automatic set_req(input int i, input logic [TW-1:0] d, input logic [XLEN-1:0] r);
    for (int m = 0; m < 2; m++) begin
      rq_valid[m][i]  = 1'b1;
      rq_dest[m][i]   = d;
      rq_result[m][i] = r;
      rq_npc[m][i]    = r + 32'd4;
      rq_pc[m][i]     = r ^ 32'h1000;
      rq_br[m][i]     = d[0];
      rq_sys[m][i]    = d[1];
    end
  endtask

  task automatic settle();
    @(negedge clock);
    for (int m = 0; m < 2; m++) begin
      mdl_gnt[m] = model_grant(m);
      act_rdy[m] = o_ready[m];
      check({pfx[m], ".req_ready"}, 64'(o_ready[m]), mdl_gnt[m] < 0 ? 64'd0 : 64'd1 << mdl_gnt[m]);
      check({pfx[m], ".cdb_valid"}, 64'(o_valid[m]), 64'(mdl[m].valid));
      check({pfx[m], ".cdb_dest"}, 64'(o_dest[m]), 64'(mdl[m].dest));
      check({pfx[m], ".cdb_result"}, 64'(o_result[m]), 64'(mdl[m].result));
      check({pfx[m], ".cdb_npc"}, 64'(o_npc[m]), 64'(mdl[m].npc));
      check({pfx[m], ".cdb_pc"}, 64'(o_pc[m]), 64'(mdl[m].pc));
      check({pfx[m], ".cdb_flags"}, 64'({o_br[m], o_sys[m]}), 64'({mdl[m].br, mdl[m].sys}));
      check({pfx[m], ".cdb_src"}, 64'(o_src[m]), 64'(mdl[m].src));
    end
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        mdl[m]    = '{default: 0};
        mdl_rr[m] = 0;
      end else if (mdl_gnt[m] >= 0) begin
        int g = mdl_gnt[m];
        mdl[m] = '{valid: 1'b1, dest: rq_dest[m][g], result: rq_result[m][g],
                   npc: rq_npc[m][g], pc: rq_pc[m][g], br: rq_br[m][g],
                   sys: rq_sys[m][g], src: g};
        mdl_rr[m] = (g + 1) % N;
      end else if (flush || cdb_ready) begin
        mdl[m].valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (act_rdy[m][i] && rq_valid[m][i]) begin
          if (refill == 1 || (refill == 2 && $urandom_range(0, 3) != 0)) new_req(m, i);
          else rq_valid[m][i] = 1'b0;
        end else if (refill == 2 && !rq_valid[m][i] && $urandom_range(0, 2) == 0) begin
          new_req(m, i);
        end
      end
    end
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    refill    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    cdb_ready = 1'b1;
    rob_head  = '0;
    for (int m = 0; m < 2; m++) begin
      mdl[m]    = '{default: 0};
      mdl_rr[m] = 0;
      rq_valid[m] = '0;
      for (int i = 0; i < N; i++) begin
        rq_dest[m][i] = '0; rq_result[m][i] = '0; rq_npc[m][i] = '0;
        rq_pc[m][i] = '0; rq_br[m][i] = 1'b0; rq_sys[m][i] = 1'b0;
      end
    end
    repeat (2) @(posedge clock);
    #1;
    step();
    reset = 1'b0;

    // Single requester: grant this cycle, result on the bus next cycle.
    set_req(1, 4'd3, 32'hDEADBEEF);
    settle();
    for (int m = 0; m < 2; m++) check({pfx[m], ".t1_ready"}, 64'(o_ready[m]), 64'b010);
    advance();
    settle();
    for (int m = 0; m < 2; m++) begin
      check({pfx[m], ".t1_valid"}, 64'(o_valid[m]), 64'd1);
      check({pfx[m], ".t1_dest"}, 64'(o_dest[m]), 64'd3);
      check({pfx[m], ".t1_result"}, 64'(o_result[m]), 64'hDEADBEEF);
      check({pfx[m], ".t1_src"}, 64'(o_src[m]), 64'd1);
    end
    advance();

    // Age order relative to head 6: dest 7 (age 1), 14 (age 8), 2 (age 12).
    rob_head = 4'd6;
    set_req(0, 4'd2, 32'h0000_0A00);
    set_req(1, 4'd7, 32'h0000_0A01);
    set_req(2, 4'd14, 32'h0000_0A02);
    settle(); check("age.t2_ready_u1", 64'(o_ready[0]), 64'b010); advance();
    settle(); check("age.t2_ready_u2", 64'(o_ready[0]), 64'b100);
    check("age.t2_src1", 64'(o_src[0]), 64'd1); advance();
    settle(); check("age.t2_ready_u0", 64'(o_ready[0]), 64'b001);
    check("age.t2_src2", 64'(o_src[0]), 64'd2); advance();
    settle(); check("age.t2_src0", 64'(o_src[0]), 64'd0); advance();

    // Round-robin with all units continuously requesting.
    reset = 1'b1; step(); reset = 1'b0;
    refill = 1;
    for (int m = 0; m < 2; m++) for (int i = 0; i < N; i++) new_req(m, i);
    for (int k = 0; k < 6; k++) begin
      settle();
      check("rr.t3_ready", 64'(o_ready[1]), 64'd1 << (k % 3));
      if (k > 0) check("rr.t3_src", 64'(o_src[1]), 64'((k - 1) % 3));
      advance();
    end
    refill = 0;
    for (int m = 0; m < 2; m++) rq_valid[m] = '0;

    // Backpressure holds dest 5; release grants unit 0 with no bubble.
    set_req(0, 4'd5, 32'h5555_0005);
    step();
    cdb_ready = 1'b0;
    set_req(0, 4'd9, 32'h9999_0009);
    for (int k = 0; k < 3; k++) begin
      settle();
      for (int m = 0; m < 2; m++) begin
        check({pfx[m], ".t4_stall_ready"}, 64'(o_ready[m]), 64'd0);
        check({pfx[m], ".t4_hold_dest"}, 64'(o_dest[m]), 64'd5);
      end
      advance();
    end
    cdb_ready = 1'b1;
    settle();
    for (int m = 0; m < 2; m++) check({pfx[m], ".t4_release_ready"}, 64'(o_ready[m]), 64'b001);
    advance();

    // Flush kills the held entry and blocks the grant for one cycle.
    cdb_ready = 1'b0;
    flush = 1'b1;
    set_req(2, 4'd11, 32'hBBBB_000B);
    settle();
    for (int m = 0; m < 2; m++) begin
      check({pfx[m], ".t4_new_dest"}, 64'(o_dest[m]), 64'd9);
      check({pfx[m], ".t5_flush_ready"}, 64'(o_ready[m]), 64'd0);
    end
    advance();
    flush = 1'b0;
    settle();
    for (int m = 0; m < 2; m++) begin
      check({pfx[m], ".t5_flushed_valid"}, 64'(o_valid[m]), 64'd0);
      check({pfx[m], ".t5_after_ready"}, 64'(o_ready[m]), 64'b100);
    end
    advance();
    settle();
    for (int m = 0; m < 2; m++) check({pfx[m], ".t5_src"}, 64'(o_src[m]), 64'd2);
    advance();

    // Reset with a held entry and pending requests.
    set_req(1, 4'd4, 32'h4444_0004);
    set_req(2, 4'd12, 32'hCCCC_000C);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    for (int m = 0; m < 2; m++) begin
      check({pfx[m], ".t6_valid"}, 64'(o_valid[m]), 64'd0);
      check({pfx[m], ".t6_result"}, 64'(o_result[m]), 64'd0);
      check({pfx[m], ".t6_src"}, 64'(o_src[m]), 64'd0);
    end
    check("rr.t6_lowest_ready", 64'(o_ready[1]), 64'b010);
    check("age.t6_oldest_ready", 64'(o_ready[0]), 64'b100);
    advance();

    // Random traffic with backpressure, flushes and occasional resets.
    refill = 2;
    for (int c = 0; c < 500; c++) begin
      cdb_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 7) == 0) rob_head = TW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
